// File: rtl/final_project_soc_otg_pkg.sv
//==============================================================================
// Module   : final_project_soc_otg_pkg
// Purpose  : Shared constants for the OTG controller input/output ports on the
//            Nios II interconnect: slave register word addresses, edge-select
//            encodings and the synchronizer warm-up helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package final_project_soc_otg_pkg;

   // Word addresses inside the OTG data-in slave
   localparam logic [1:0] OTG_IN_DATA     = 2'd0;
   localparam logic [1:0] OTG_IN_RESERVED = 2'd1;
   localparam logic [1:0] OTG_IN_IRQ_MASK = 2'd2;
   localparam logic [1:0] OTG_IN_EDGE_CAP = 2'd3;

   // Edge-select encodings for the EDGE_TYPE parameter
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // Number of cycles after reset before edge detection is trusted: the
   // synchronizer chain plus the one-cycle delayed copy must both have been
   // loaded from real pin values.
   function automatic logic [2:0] warmup_limit(input int sync_stages);
      return 3'(sync_stages + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/final_project_soc_otg_sync.sv
//==============================================================================
// Module   : final_project_soc_otg_sync
// Purpose  : WIDTH-bit, SYNC_STAGES-deep flop-chain synchronizer for
//            asynchronous OTG pins. Asynchronous active-low reset clears
//            every stage to 0.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            async_in   - asynchronous pin inputs   [WIDTH-1:0]
//            sync_out   - synchronized pin values   [WIDTH-1:0]
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module final_project_soc_otg_sync #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   // Stage 0 samples the pins; stage SYNC_STAGES-1 is the trusted output.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
      end else begin
         chain[0] <= async_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            chain[s] <= chain[s-1];
         end
      end
   end

   assign sync_out = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/final_project_soc_otg_data_in.sv
//==============================================================================
// Module   : final_project_soc_otg_data_in
// Purpose  : Avalon-MM input port returning the OTG controller data bus and
//            status pins to the Nios II. Pins are synchronized, exposed at
//            DATA, and per-bit edges are latched into EDGE_CAP (write-1-to-
//            clear). Enabled captured edges drive a level interrupt.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            address    - register word address [1:0]
//            chipselect - slave select
//            write_n    - active-low write strobe (qualified by chipselect)
//            writedata  - write data [31:0]
//            in_port    - asynchronous OTG pins [WIDTH-1:0]
//            readdata   - registered read data, zero-extended [31:0]
//            irq        - level interrupt, active-high
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module final_project_soc_otg_data_in
   import final_project_soc_otg_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [2:0] WARM_LIMIT = warmup_limit(SYNC_STAGES);

   logic [WIDTH-1:0] data_sync;
   logic [WIDTH-1:0] data_d1;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_vec;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] cap_clear;
   logic [WIDTH-1:0] wr_bits;
   logic [2:0]       warm_cnt;
   logic             warm_done;
   logic             wr_en;
   logic [31:0]      read_mux;
   logic             unused_wdata;

   //---------------------------------------------------------------------------
   // Pin synchronizer
   //---------------------------------------------------------------------------
   final_project_soc_otg_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (in_port),
      .sync_out (data_sync)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_d1 <= '0;
      end else begin
         data_d1 <= data_sync;
      end
   end

   //---------------------------------------------------------------------------
   // Warm-up: pins already high at reset would otherwise look like rising
   // edges while the all-zero chain fills, so edges are ignored until both
   // data_sync and data_d1 carry real pin samples.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_cnt <= '0;
      end else if (!warm_done) begin
         warm_cnt <= warm_cnt + 3'd1;
      end
   end

   assign warm_done = (warm_cnt == WARM_LIMIT);

   //---------------------------------------------------------------------------
   // Edge detection
   //---------------------------------------------------------------------------
   generate
      if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_falling
         assign edge_raw = ~data_sync & data_d1;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
         assign edge_raw = data_sync ^ data_d1;
      end else begin : g_edge_rising
         assign edge_raw = data_sync & ~data_d1;
      end
   endgenerate

   assign edge_vec = warm_done ? edge_raw : '0;

   //---------------------------------------------------------------------------
   // Register writes
   //---------------------------------------------------------------------------
   assign wr_en        = chipselect && !write_n;
   assign wr_bits      = writedata[WIDTH-1:0];
   assign cap_clear    = (wr_en && (address == OTG_IN_EDGE_CAP)) ? wr_bits : '0;
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
      end else if (wr_en && (address == OTG_IN_IRQ_MASK)) begin
         irq_mask <= wr_bits;
      end
   end

   // Clear is applied before the new edge is OR-ed in, so an edge arriving
   // in the same cycle as a W1C keeps its bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
      end else begin
         edge_cap <= (edge_cap & ~cap_clear) | edge_vec;
      end
   end

   //---------------------------------------------------------------------------
   // Read path: loads every cycle, independent of chipselect
   //---------------------------------------------------------------------------
   always_comb begin
      read_mux = '0;
      case (address)
         OTG_IN_DATA:     read_mux[WIDTH-1:0] = data_sync;
         OTG_IN_IRQ_MASK: read_mux[WIDTH-1:0] = irq_mask;
         OTG_IN_EDGE_CAP: read_mux[WIDTH-1:0] = edge_cap;
         default:         read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= read_mux;
      end
   end

   // Driven from registers only: no combinational pin-to-irq path.
   assign irq = |(edge_cap & irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_final_project_soc_otg_data_in.sv
//==============================================================================
// Module   : tb_final_project_soc_otg_data_in
// Purpose  : Self-checking bench for final_project_soc_otg_data_in. Two
//            instances (rising-edge and any-edge) share one bus and one set of
//            pins; a behavioural model predicts readdata/irq every cycle and
//            directed reads pin the model with literal values.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_final_project_soc_otg_data_in;

   localparam int W = 16;
   localparam int S = 2;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b1;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = 32'd0;
   logic [W-1:0] in_port   = '0;

   logic [31:0] readdata_r, readdata_a;
   logic        irq_r, irq_a;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   final_project_soc_otg_data_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata_r), .irq(irq_r)
   );

   final_project_soc_otg_data_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata_a), .irq(irq_a)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Behavioural model. Index 0 = rising-edge instance, 1 = any-edge instance.
   // Pin samples travel through a queue that delays them by S clock edges;
   // edges are judged on consecutive synchronized values once enough edges
   // have passed since reset.
   //---------------------------------------------------------------------------
   logic [W-1:0] pin_q[$];
   logic [W-1:0] m_sync = '0;
   logic [W-1:0] m_prev = '0;
   logic [W-1:0] m_cap[2] = '{default: '0};
   logic [W-1:0] m_mask = '0;
   logic [31:0]  m_rd[2] = '{default: '0};
   int           edges_seen = 0;

   function automatic logic [31:0] reg_val(input int k, input logic [1:0] a);
      case (a)
         2'd0:    return {16'h0, m_sync};
         2'd2:    return {16'h0, m_mask};
         2'd3:    return {16'h0, m_cap[k]};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      logic [W-1:0] rise, fall, clr;
      if (!reset_n) begin
         pin_q = {};
         for (int i = 0; i < S - 1; i++) pin_q.push_back('0);
         m_sync = '0; m_prev = '0; m_mask = '0;
         m_cap[0] = '0; m_cap[1] = '0; m_rd[0] = 32'h0; m_rd[1] = 32'h0;
         edges_seen = 0;
      end else begin
         m_rd[0] = reg_val(0, address);
         m_rd[1] = reg_val(1, address);
         rise = m_sync & ~m_prev;
         fall = ~m_sync & m_prev;
         if (edges_seen < S + 1) begin
            rise = '0;
            fall = '0;
         end
         clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
         m_cap[0] = (m_cap[0] & ~clr) | rise;
         m_cap[1] = (m_cap[1] & ~clr) | rise | fall;
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
         pin_q.push_back(in_port);
         m_prev = m_sync;
         m_sync = pin_q.pop_front();
         if (edges_seen < S + 1) edges_seen++;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_rd_rise", readdata_r, m_rd[0]);
         chk("cyc_rd_any",  readdata_a, m_rd[1]);
         chk("cyc_irq_rise", {31'b0, irq_r}, {31'b0, |(m_cap[0] & m_mask)});
         chk("cyc_irq_any",  {31'b0, irq_a}, {31'b0, |(m_cap[1] & m_mask)});
      end
   end

   //---------------------------------------------------------------------------
   // Bus helpers
   //---------------------------------------------------------------------------
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] rr, output logic [31:0] ra);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk);
      #1;
      rr = readdata_r; ra = readdata_a;
      chipselect = 1'b0;
   endtask

   task automatic set_pins(input logic [W-1:0] v);
      @(negedge clk);
      in_port = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] rr, ra;

   initial begin
      // Reset with all pins high: warm-up must hide the apparent edges.
      #2 reset_n = 1'b0;
      in_port = 16'hFFFF;
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      reset_n  = 1'b1;
      idle(10);
      chk("warm_irq_r", {31'b0, irq_r}, 32'h0);
      chk("warm_irq_a", {31'b0, irq_a}, 32'h0);
      bus_read(2'd0, rr, ra);
      chk("warm_data_r", rr, 32'h0000FFFF);
      chk("warm_data_a", ra, 32'h0000FFFF);
      bus_read(2'd3, rr, ra);
      chk("warm_cap_r", rr, 32'h0);
      chk("warm_cap_a", ra, 32'h0);

      // Rising edge on bit 0 with mask 0x0001: irq after edge k+2.
      set_pins(16'h0000);
      idle(5);
      bus_write(2'd3, 32'hFFFF);
      bus_write(2'd2, 32'h0001);
      set_pins(16'h0001);
      repeat (2) @(posedge clk);
      #1 chk("edge_k1_irq_r", {31'b0, irq_r}, 32'h0);
      @(posedge clk);
      #1 chk("edge_k2_irq_r", {31'b0, irq_r}, 32'h1);
      bus_read(2'd3, rr, ra);
      chk("edge0_cap_r", rr, 32'h0001);
      bus_write(2'd3, 32'h0001);
      chk("w1c_irq_r", {31'b0, irq_r}, 32'h0);

      // Edge on bit 3 coincides with W1C of bit 3: the edge wins.
      set_pins(16'h0009);
      @(negedge clk);
      bus_write(2'd3, 32'h0008);
      bus_read(2'd3, rr, ra);
      chk("race_cap_r", rr, 32'h0008);
      chk("race_cap_a", ra, 32'h0008);
      bus_write(2'd3, 32'h0008);
      bus_read(2'd3, rr, ra);
      chk("clr_cap_r", rr, 32'h0);

      // Masked capture: no irq until the mask opens.
      bus_write(2'd2, 32'h0000);
      set_pins(16'h00F9);
      idle(4);
      set_pins(16'h0009);
      idle(4);
      bus_read(2'd3, rr, ra);
      chk("mask_cap_r", rr, 32'h00F0);
      chk("mask_cap_a", ra, 32'h00F0);
      chk("mask_irq_r", {31'b0, irq_r}, 32'h0);
      bus_write(2'd2, 32'h0010);
      chk("unmask_irq_r", {31'b0, irq_r}, 32'h1);

      // Any-edge capture across a full byte swap.
      bus_write(2'd3, 32'hFFFF);
      set_pins(16'h00FF);
      idle(5);
      bus_write(2'd3, 32'hFFFF);
      set_pins(16'hFF00);
      idle(5);
      bus_read(2'd3, rr, ra);
      chk("swap_cap_a", ra, 32'h0000FFFF);
      chk("swap_cap_r", rr, 32'h0000FF00);
      bus_read(2'd1, rr, ra);
      chk("rsvd_r", rr, 32'h0);
      chk("rsvd_a", ra, 32'h0);
      @(negedge clk);
      address = 2'd0;
      #1 chk("lat_before_r", readdata_r, 32'h0);
      @(posedge clk);
      #1 chk("lat_after_r", readdata_r, 32'h0000FF00);

      // Asynchronous reset mid-operation.
      bus_write(2'd3, 32'hFFFF);
      bus_write(2'd2, 32'h0005);
      set_pins(16'h0005);
      idle(5);
      bus_read(2'd3, rr, ra);
      chk("pre_rst_cap_r", rr, 32'h0005);
      chk("pre_rst_irq_r", {31'b0, irq_r}, 32'h1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_irq_r", {31'b0, irq_r}, 32'h0);
      chk("async_irq_a", {31'b0, irq_a}, 32'h0);
      chk("async_rd_r", readdata_r, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(8);
      bus_read(2'd2, rr, ra);
      chk("post_rst_mask_r", rr, 32'h0);
      bus_read(2'd3, rr, ra);
      chk("post_rst_cap_r", rr, 32'h0);
      chk("post_rst_cap_a", ra, 32'h0);

      @(negedge clk);
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/final_project_soc_otg_data_in.md
# final_project_soc_otg_data_in

Avalon-MM memory-mapped input port that returns the OTG controller's 16-bit data bus (and other OTG status pins) to the Nios II. It is the read-side counterpart of the OTG data output port on the same system interconnect. The block synchronizes the asynchronous pins, exposes them at a data register, and latches per-bit edge events into a capture register. Enabled edge events drive a level interrupt that software clears by writing 1s.

## Interface
- `WIDTH`, default 16: number of input pins, 1..32.
- `EDGE_TYPE`, default 0: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, default 2: synchronizer depth, 2..4.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  2  word address of the register within the slave.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe. Meaningful only with `chipselect`.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous pins from the OTG chip.
- `readdata`  out  32  registered read data, zero-extended above WIDTH.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 = DATA (RO): synchronized pin value `data_sync`.
  - 1 = reserved: reads 0, writes ignored.
  - 2 = IRQ_MASK (RW, WIDTH bits).
  - 3 = EDGE_CAP (R/W1C, WIDTH bits).
  - Writes to address 0 are ignored.
- Synchronizer: an SYNC_STAGES-deep flop chain per bit produces `data_sync`. `data_d1` holds `data_sync` delayed by one cycle.
- Edge vector, selected by EDGE_TYPE:
  - rising = `data_sync & ~data_d1`
  - falling = `~data_sync & data_d1`
  - any = XOR of the two.
- Warm-up counter: 3 bits, cleared at reset, increments each cycle until it saturates at SYNC_STAGES+1. The edge vector is forced to 0 until saturation. This suppresses false edges from pins that are already high at reset.
- EDGE_CAP[i]:
  - set when edge[i] = 1.
  - cleared by a write to address 3 with `writedata[i]` = 1.
  - An edge in the same cycle as the clear wins: the bit stays 1.
  - Bits written as 0 are unchanged.
- IRQ_MASK: a write to address 2 loads `writedata[WIDTH-1:0]`.
- `irq` = OR-reduce(EDGE_CAP & IRQ_MASK). It is a combinational function of registers only, with no pin-to-irq combinational path.
- Read: every cycle, `readdata` loads the zero-extended mux of `address`. The load happens regardless of `chipselect`. Reads have no side effects.
- Reset values:
  - synchronizer flops, `data_d1`, warm-up counter, EDGE_CAP, IRQ_MASK, `readdata`: all 0.
  - `irq` = 0.

## Timing
- Read latency is 1 cycle: the value is sampled at the edge that ends the address cycle.
- A pin change that meets setup before edge k appears in `data_sync` after edge k+SYNC_STAGES-1.
- The matching EDGE_CAP bit and `irq` assert after edge k+SYNC_STAGES. `readdata` shows the new value one edge after that.
- An IRQ_MASK or EDGE_CAP write takes effect at the write edge. `irq` updates in the same cycle.
- Glitches shorter than one clock may be missed. This is acceptable: the OTG pins are level signals.
- Reset asserted mid-operation: all state clears asynchronously. Warm-up restarts on release. Edges during warm-up are lost by design.

## Structure
- Shared package `final_project_soc_otg_pkg`:
  - address constants `OTG_IN_DATA`, `OTG_IN_IRQ_MASK`, `OTG_IN_EDGE_CAP`.
  - edge encodings `EDGE_RISING`, `EDGE_FALLING`, `EDGE_ANY`.
- Sub-module `final_project_soc_otg_sync`: parameterized WIDTH × SYNC_STAGES synchronizer with async reset to 0. Reusable by other OTG input paths.
- Top level contains the warm-up counter, edge detect, registers, read mux and irq.

## Test plan
- Reset with `in_port` = 0xFFFF, release, wait 10 cycles -> DATA reads 0xFFFF, EDGE_CAP reads 0, `irq` = 0 throughout. This checks warm-up suppression.
- EDGE_TYPE=0, IRQ_MASK=0x0001, toggle `in_port[0]` 0→1 at cycle k -> EDGE_CAP = 0x0001 and `irq` = 1 after edge k+2. Write 0x0001 to address 3 -> `irq` = 0 on the next cycle.
- Raise bit 3 in the same cycle as a W1C write of 0x0008 lands -> EDGE_CAP[3] stays 1.
- IRQ_MASK=0x0000, pulse bits 0x00F0 -> EDGE_CAP = 0x00F0 and `irq` stays 0. Then write IRQ_MASK=0x0010 -> `irq` = 1 in the same cycle.
- EDGE_TYPE=2, drive `in_port` 0x00FF→0xFF00 -> EDGE_CAP = 0xFFFF. Address 1 reads 0x00000000. DATA reads 0x0000FF00 with 1-cycle latency.
- Assert `reset_n` while EDGE_CAP = 0x0005 and IRQ_MASK = 0x0005 -> `irq`, EDGE_CAP and IRQ_MASK go to 0 immediately, without waiting for a clock edge.
